sum_accumulator: RTL and testbench
==================================

# sum_accumulator

Downstream stage of the 3-operand 8-bit adder. Collects the adder's 10-bit results ({carry, sum}) over a valid/ready handshake and adds them into a wider running total. When a frame of COUNT results has been summed, or when an early flush arrives, it presents the frame total and the frame's sample count on a valid/ready output port.

## Interface

Parameters:
- COUNT, 4: results per full frame; legal range 2 to 16.
- ACC_W, 14: accumulator and total width; must be at least 10 + clog2(COUNT + 1). Elaboration fails otherwise.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- in_valid  input  1  in_sum and in_carry are valid.
- in_ready  output  1  block can accept a result.
- in_sum  input  8  adder sum.
- in_carry  input  2  adder carry.
- flush  input  1  close the current frame early; single-cycle pulse.
- out_valid  output  1  out_total and out_count are valid.
- out_ready  input  1  downstream accepts the frame.
- out_total  output  ACC_W  frame total.
- out_count  output  5  number of results in the frame, from 1 to COUNT.

## Operation

- Value of one result: the 10-bit quantity {in_carry, in_sum}, zero-extended to ACC_W. Its maximum is 765.
- No overflow is possible: the width rule guarantees COUNT × 765 fits in ACC_W.
- There are two states, ACC and OUT, defined in a package enum.
- ACC state:
  - in_ready = 1 and out_valid = 0.
  - Accept condition: in_valid and in_ready. On accept, acc <= acc + value and cnt <= cnt + 1.
  - On the accept that makes cnt equal COUNT: load out_total = acc + value, load out_count = COUNT, clear acc and cnt, and go to OUT.
  - On flush with cnt > 0 or a same-cycle accept: the frame closes. A result accepted in the same cycle is included in out_total and out_count. Clear acc and cnt, and go to OUT.
  - On flush with cnt = 0 and no accept: ignored; the block stays in ACC.
- OUT state:
  - in_ready = 0 and out_valid = 1.
  - out_total and out_count hold stable until the handshake.
  - flush is ignored.
  - On out_valid and out_ready: go to ACC on the next cycle.
- Valid/ready rules:
  - The upstream side must hold its data stable while in_valid = 1 and in_ready = 0.
  - out_valid never drops without a handshake.
- Reset, asynchronous, any state including mid-frame:
  - state = ACC, acc = 0, cnt = 0.
  - out_valid = 0, out_total = 0, out_count = 0.
  - in_ready = 0 while rst_n is low; in_ready = 1 from the first clock after release.
  - A partial frame is discarded.

## Timing

- in_ready and out_valid are decoded from registered state only; there is no combinational path from input to output.
- Latency: out_valid rises on the clock edge that accepts the closing result or flush, so it is visible in the next cycle.
- The block accepts one result per cycle in ACC.
- The cycle in which the output handshakes accepts no input. The first input after the handshake can be accepted one cycle later.
- Minimum frame period is COUNT + 1 cycles when out_ready is held high.
- out_ready held low stalls upstream indefinitely: in_ready stays 0 and no data is lost.
- A flush arriving together with the COUNT-th accept is a single close with out_count = COUNT; it does not produce an extra empty frame.

## Structure

- Package sum_acc_pkg contains:
  - the state enum {ACC, OUT};
  - the result_t typedef, a 10-bit vector;
  - the constant RESULT_MAX = 765.
- Single flat module. A sub-module is not natural here: the counter and accumulator are a few lines each and share close logic with the state machine.

## Test plan

- Full frame: COUNT = 4, four back-to-back results of 765 (carry = 2, sum = 0xFD), out_ready = 1 -> out_total = 3060, out_count = 4, out_valid one cycle after the 4th accept.
- Early flush: results 10, 20, 30 with flush on the 3rd accept -> out_total = 60, out_count = 3. The next frame starts from 0.
- Idle flush: flush pulse with cnt = 0 -> no out_valid; state stays in ACC.
- Backpressure: out_ready = 0 for 5 cycles after a frame closes -> in_ready = 0, out_total stable, in_valid data held. Handshake on cycle 6, then in_ready = 1 on the next cycle.
- Stall on input: in_valid toggled 1,0,1,0 with values 1, 2, 3, 4 -> only valid cycles count; out_total = 10.
- Reset mid-frame: rst_n low after 2 accepts -> out_valid = 0 and in_ready = 0 immediately. After release, four results of 1 give out_total = 4.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// -----------------------------------------------------------------------------
// sum_acc_pkg
// Shared types and constants for the sum_accumulator stage that sits behind
// the 3-operand 8-bit adder.
//   state_t    : frame state, ACC (collecting results) or OUT (presenting total)
//   result_t   : one adder result, {carry[1:0], sum[7:0]}
//   RESULT_MAX : largest value a single adder result can take (3 x 255)
// -----------------------------------------------------------------------------
package sum_acc_pkg;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  typedef logic [9:0] result_t;

  localparam int RESULT_MAX = 765;

endpackage

// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
// Collects 10-bit adder results over a valid/ready handshake and sums them
// into a running total. A frame closes after COUNT results or on an early
// flush, and the frame total plus its sample count are then presented on a
// valid/ready output port until the downstream accepts them.
//
// Parameters
//   COUNT     : results per full frame (2..16)
//   ACC_W     : accumulator / total width, >= 10 + clog2(COUNT + 1)
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_sum / in_carry carry a result
//   in_ready  : block can accept a result (ACC state, not in reset)
//   in_sum    : adder sum
//   in_carry  : adder carry
//   flush     : single-cycle pulse closing the current frame early
//   out_valid : out_total / out_count hold a closed frame
//   out_ready : downstream accepts the frame
//   out_total : frame total
//   out_count : number of results in the frame (1..COUNT)
// -----------------------------------------------------------------------------
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int ACC_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_sum,
  input  logic [1:0]       in_carry,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [4:0]       out_count
);

  // Reject illegal parameterisations at elaboration time.
  if (COUNT < 2 || COUNT > 16) begin : g_bad_count
    $error("sum_accumulator: COUNT must be in 2..16");
  end
  if (ACC_W < 10 + $clog2(COUNT + 1)) begin : g_bad_width
    $error("sum_accumulator: ACC_W too narrow for COUNT results");
  end

  state_t           state;
  logic             alive;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] value;
  logic [4:0]       cnt;
  logic [4:0]       cnt_next;
  result_t          result;
  logic             accept;
  logic             full;
  logic             close;

  // alive is low only between reset and the first clock after release, which
  // keeps in_ready low during reset while still coming purely from flops.
  assign in_ready  = alive && (state == ACC);
  assign out_valid = (state == OUT);

  assign result   = {in_carry, in_sum};
  assign value    = ACC_W'(result);
  assign accept   = in_valid && in_ready;
  assign acc_next = acc + (accept ? value : '0);
  assign cnt_next = cnt + {4'd0, accept};

  // cnt_next already includes a same-cycle accept, so a flush that coincides
  // with the COUNT-th accept is one close, and a flush on an empty frame with
  // no accept leaves cnt_next at zero and is ignored.
  assign full  = accept && (cnt_next == 5'(COUNT));
  assign close = full || (flush && (cnt_next != 5'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      alive     <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      out_total <= '0;
      out_count <= '0;
    end else begin
      alive <= 1'b1;
      if (state == ACC) begin
        if (close) begin
          out_total <= acc_next;
          out_count <= cnt_next;
          acc       <= '0;
          cnt       <= '0;
          state     <= OUT;
        end else begin
          acc <= acc_next;
          cnt <= cnt_next;
        end
      end else if (out_ready) begin
        state <= ACC;
      end
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator
// Self-checking bench for sum_accumulator (COUNT = 4, ACC_W = 14): a table of
// directed vectors, hand-written backpressure and reset sequences, and a
// randomized run compared against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_sum_accumulator;

  localparam int COUNT = 4;
  localparam int ACC_W = 14;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_sum = '0;
  logic [1:0]       in_carry = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_total;
  logic [4:0]       out_count;

  int errors = 0;
  int checks = 0;

  // Reference model: the open frame as a plain sum and count, plus the closed
  // frame awaiting the downstream handshake.
  int m_sum, m_n, m_tot, m_cnt;
  bit m_hold, m_alive, m_took;

  typedef struct {
    bit valid;
    int value;
    bit flush;
    bit ready;
    bit exp_ready;
    bit exp_valid;
    int exp_total;
    int exp_count;
  } vec_t;

  vec_t vecs[$];

  sum_accumulator #(.COUNT(COUNT), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_total (out_total),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    m_sum = 0; m_n = 0; m_tot = 0; m_cnt = 0;
    m_hold = 1'b0; m_alive = 1'b0; m_took = 1'b0;
  endfunction

  // Advance the model by one clock using the inputs about to be sampled.
  function automatic void modelStep();
    int value;
    value  = int'({in_carry, in_sum});
    m_took = in_valid && m_alive && !m_hold;
    if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else begin
      if (m_took) begin
        m_sum = m_sum + value;
        m_n   = m_n + 1;
      end
      if ((m_took && m_n == COUNT) || (flush && m_n > 0)) begin
        m_tot  = m_sum;
        m_cnt  = m_n;
        m_sum  = 0;
        m_n    = 0;
        m_hold = 1'b1;
      end
    end
    m_alive = 1'b1;
  endfunction

  task automatic compare(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input bit exp_ready, input bit exp_valid,
                             input int exp_total, input int exp_count);
    compare({name, " in_ready"}, int'(in_ready), int'(exp_ready));
    compare({name, " out_valid"}, int'(out_valid), int'(exp_valid));
    if (exp_valid) begin
      compare({name, " out_total"}, int'(out_total), exp_total);
      compare({name, " out_count"}, int'(out_count), exp_count);
    end
  endtask

  // Drive one cycle of inputs, step the model, and land 1 time unit after the edge.
  task automatic applyStimulus(input bit v, input int value, input bit f, input bit r);
    in_valid  = v;
    in_carry  = 2'(value >> 8);
    in_sum    = 8'(value & 255);
    flush     = f;
    out_ready = r;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check the asynchronous effect, then release
  // away from the clock edge.
  task automatic doReset(input string name);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    modelReset();
    #1;
    compare({name, " reset out_valid"}, int'(out_valid), 0);
    compare({name, " reset in_ready"}, int'(in_ready), 0);
    compare({name, " reset out_total"}, int'(out_total), 0);
    compare({name, " reset out_count"}, int'(out_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare({name, " in_ready before first clock"}, int'(in_ready), 0);
  endtask

  task automatic addRow(input bit v, input int value, input bit f, input bit r,
                        input bit er, input bit ev, input int et, input int ec);
    vec_t row;
    row.valid = v; row.value = value; row.flush = f; row.ready = r;
    row.exp_ready = er; row.exp_valid = ev; row.exp_total = et; row.exp_count = ec;
    vecs.push_back(row);
  endtask

  initial begin
    int val;
    bit v;
    modelReset();

    // Table: full frame, early flush, idle flush, stalled input,
    // flush with the COUNT-th accept, flush while presenting.
    addRow(0,   0, 0, 1,  1, 0,    0, 0);
    addRow(1, 765, 0, 1,  1, 0,    0, 0);
    addRow(1, 765, 0, 1,  1, 0,    0, 0);
    addRow(1, 765, 0, 1,  1, 0,    0, 0);
    addRow(1, 765, 0, 1,  0, 1, 3060, 4);
    addRow(0,   0, 0, 1,  1, 0,    0, 0);
    addRow(1,  10, 0, 1,  1, 0,    0, 0);
    addRow(1,  20, 0, 1,  1, 0,    0, 0);
    addRow(1,  30, 1, 1,  0, 1,   60, 3);
    addRow(0,   0, 0, 1,  1, 0,    0, 0);
    addRow(0,   0, 1, 1,  1, 0,    0, 0);
    addRow(0,   0, 0, 1,  1, 0,    0, 0);
    addRow(1,   1, 0, 1,  1, 0,    0, 0);
    addRow(0,  99, 0, 1,  1, 0,    0, 0);
    addRow(1,   2, 0, 1,  1, 0,    0, 0);
    addRow(0,  99, 0, 1,  1, 0,    0, 0);
    addRow(1,   3, 0, 1,  1, 0,    0, 0);
    addRow(0,  99, 0, 1,  1, 0,    0, 0);
    addRow(1,   4, 0, 1,  0, 1,   10, 4);
    addRow(0,   0, 0, 1,  1, 0,    0, 0);
    addRow(1,   5, 0, 1,  1, 0,    0, 0);
    addRow(1,   6, 0, 1,  1, 0,    0, 0);
    addRow(1,   7, 0, 1,  1, 0,    0, 0);
    addRow(1,   8, 1, 1,  0, 1,   26, 4);
    addRow(0,   0, 0, 1,  1, 0,    0, 0);
    addRow(0,   0, 0, 1,  1, 0,    0, 0);
    addRow(1, 100, 1, 1,  0, 1,  100, 1);
    addRow(0,   0, 1, 0,  0, 1,  100, 1);
    addRow(0,   0, 0, 1,  1, 0,    0, 0);
    addRow(0,   0, 0, 1,  1, 0,    0, 0);

    #2;
    compare("por out_valid", int'(out_valid), 0);
    compare("por in_ready", int'(in_ready), 0);
    compare("por out_total", int'(out_total), 0);
    compare("por out_count", int'(out_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare("por in_ready before first clock", int'(in_ready), 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].value, vecs[i].flush, vecs[i].ready);
      checkOutput($sformatf("row%0d", i), vecs[i].exp_ready, vecs[i].exp_valid,
                  vecs[i].exp_total, vecs[i].exp_count);
    end

    // Backpressure: frame of 1000 held for 5 stalled cycles with input held.
    applyStimulus(1, 100, 0, 1); checkOutput("bp fill", 1, 0, 0, 0);
    applyStimulus(1, 200, 0, 1); checkOutput("bp fill", 1, 0, 0, 0);
    applyStimulus(1, 300, 0, 1); checkOutput("bp fill", 1, 0, 0, 0);
    applyStimulus(1, 400, 0, 1); checkOutput("bp close", 0, 1, 1000, 4);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 5, 0, 0);
      checkOutput($sformatf("bp stall%0d", k), 0, 1, 1000, 4);
    end
    applyStimulus(1, 5, 0, 1); checkOutput("bp handshake", 1, 0, 0, 0);
    applyStimulus(1, 5, 0, 1); checkOutput("bp resume", 1, 0, 0, 0);
    applyStimulus(1, 5, 0, 1); checkOutput("bp resume", 1, 0, 0, 0);
    applyStimulus(1, 5, 0, 1); checkOutput("bp resume", 1, 0, 0, 0);
    applyStimulus(1, 5, 0, 1); checkOutput("bp held data frame", 0, 1, 20, 4);
    applyStimulus(0, 0, 0, 1); checkOutput("bp drain", 1, 0, 0, 0);

    // Reset mid-frame discards the partial frame.
    applyStimulus(1, 7, 0, 1); checkOutput("mid partial", 1, 0, 0, 0);
    applyStimulus(1, 8, 0, 1); checkOutput("mid partial", 1, 0, 0, 0);
    doReset("mid");
    applyStimulus(0, 0, 0, 1); checkOutput("mid first clock", 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, 1);
      checkOutput("mid ones", 1, 0, 0, 0);
    end
    applyStimulus(1, 1, 0, 1); checkOutput("mid ones frame", 0, 1, 4, 4);
    applyStimulus(0, 0, 0, 1); checkOutput("mid drain", 1, 0, 0, 0);

    // Randomized traffic against the model; stalled input data is held.
    val = 0;
    v   = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!(in_valid && !m_took)) begin
        v   = ($urandom_range(0, 9) < 7);
        val = $urandom_range(0, 765);
      end
      applyStimulus(v, val, ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 6));
      checkOutput("random", m_alive && !m_hold, m_hold, m_tot, m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
